// File: rtl/fan_pwm_gen_pkg.sv
// fan_pwm_gen_pkg: state encodings and duty constants shared by the fan PWM generator.
package fan_pwm_gen_pkg;
   typedef enum logic [2:0] {
      FAN_OFF      = 3'd0,
      FAN_KICK     = 3'd1,
      FAN_RAMP     = 3'd2,
      FAN_RUN      = 3'd3,
      FAN_FAILSAFE = 3'd4
   } fanState_t;
   localparam logic [7:0] FanDutyFull = 8'hFF;
   localparam logic [7:0] FanDutyOff  = 8'h00;
   function automatic logic [7:0] fanTarget(input logic [7:0] duty, input logic [7:0] minDuty);
      return (duty < minDuty) ? minDuty : duty;
   endfunction
endpackage

// File: rtl/fan_pwm_gen_if.sv
// fan_pwm_gen_if: register-file controls into the fan PWM generator and its readback.
interface fan_pwm_gen_if;
   import fan_pwm_gen_pkg::*;
   logic       Enable;
   logic [7:0] DutyReg;
   logic       TachFault;
   logic       FanPWM;
   logic [7:0] CurDuty;
   fanState_t  FanState;
   logic       PeriodTick;
   modport master(output Enable, DutyReg, TachFault, input FanPWM, CurDuty, FanState, PeriodTick);
   modport slave(input Enable, DutyReg, TachFault, output FanPWM, CurDuty, FanState, PeriodTick);
endinterface

// File: rtl/fan_pwm_core.sv
// fan_pwm_core: 256-clock PWM period counter, end-of-period tick and registered duty comparator.
module fan_pwm_core
   import fan_pwm_gen_pkg::*;
(
   input  logic       CLKi,
   input  logic       ResetNi,
   input  logic [7:0] Duty,
   input  logic       ForceOff,
   output logic       FanPWM,
   output logic       PeriodTick
);
   logic [7:0] pCnt;
   logic [7:0] pCntNext;
   assign pCntNext   = pCnt + 8'd1;
   assign PeriodTick = pCnt == 8'hFF;
   // Compare the upcoming count with the upcoming duty so FanPWM lines up with pCnt.
   always_ff @(posedge CLKi or negedge ResetNi) begin
      if (!ResetNi) begin
         pCnt   <= 8'h00;
         FanPWM <= 1'b0;
      end else begin
         pCnt   <= pCntNext;
         FanPWM <= !ForceOff && (pCntNext < Duty || Duty == FanDutyFull);
      end
   end
endmodule

// File: rtl/fan_pwm_gen.sv
// fan_pwm_gen: fan speed command with kick-start, rate-limited ramp, minimum-duty clamp
// and a tach-fault failsafe that forces full speed.
module fan_pwm_gen
   import fan_pwm_gen_pkg::*;
#(
   parameter int         KICK_PERIODS = 64,
   parameter int         RAMP_DIV     = 4,
   parameter logic [7:0] MIN_DUTY     = 8'h40,
   parameter int         FAULT_HOLD   = 128
) (
   input logic          CLKi,
   input logic          ResetNi,
   fan_pwm_gen_if.slave fanBus
);
   fanState_t  state, stateNext;
   logic [7:0] curDuty, dutyNext, dutyStep, target;
   logic [7:0] kickCnt, kickNext, rampCnt, rampNext, holdCnt, holdNext;
   logic       runReq, tick, forceOff;

   assign runReq   = fanBus.Enable && fanBus.DutyReg != FanDutyOff;
   assign target   = fanTarget(fanBus.DutyReg, MIN_DUTY);
   assign dutyStep = (curDuty < target) ? curDuty + 8'd1 : curDuty - 8'd1;

   always_ff @(posedge CLKi or negedge ResetNi) begin
      if (!ResetNi) begin
         state   <= FAN_OFF;
         curDuty <= FanDutyOff;
         kickCnt <= 8'h00;
         rampCnt <= 8'h00;
         holdCnt <= 8'h00;
      end else begin
         state   <= stateNext;
         curDuty <= dutyNext;
         kickCnt <= kickNext;
         rampCnt <= rampNext;
         holdCnt <= holdNext;
      end
   end

   // Disable outranks a tach fault; a fault acts at once, everything else waits for the tick.
   always_comb begin
      stateNext = state;
      dutyNext  = curDuty;
      kickNext  = kickCnt;
      rampNext  = rampCnt;
      holdNext  = holdCnt;
      if (!runReq) begin
         if (tick && state != FAN_OFF) begin
            stateNext = FAN_OFF;
            dutyNext  = FanDutyOff;
            kickNext  = 8'h00;
            rampNext  = 8'h00;
            holdNext  = 8'h00;
         end
      end else if (fanBus.TachFault) begin
         stateNext = FAN_FAILSAFE;
         dutyNext  = FanDutyFull;
         holdNext  = 8'h00;
      end else if (tick) begin
         case (state)
            FAN_OFF: begin
               stateNext = FAN_KICK;
               dutyNext  = FanDutyFull;
               kickNext  = 8'h00;
            end
            FAN_KICK: begin
               kickNext = kickCnt + 8'd1;
               if (kickCnt == 8'(KICK_PERIODS - 1)) begin
                  stateNext = FAN_RAMP;
                  rampNext  = 8'h00;
               end
            end
            FAN_RAMP:
               if (curDuty == target)
                  stateNext = FAN_RUN;
               else if (rampCnt == 8'(RAMP_DIV - 1)) begin
                  rampNext  = 8'h00;
                  dutyNext  = dutyStep;
                  stateNext = (dutyStep == target) ? FAN_RUN : FAN_RAMP;
               end else
                  rampNext = rampCnt + 8'd1;
            FAN_RUN:
               if (curDuty != target) begin
                  stateNext = FAN_RAMP;
                  rampNext  = 8'h00;
               end
            FAN_FAILSAFE: begin
               holdNext = holdCnt + 8'd1;
               if (holdCnt == 8'(FAULT_HOLD - 1)) begin
                  stateNext = FAN_RAMP;
                  rampNext  = 8'h00;
               end
            end
            default: stateNext = FAN_OFF;
         endcase
      end
   end

   always_comb begin
      fanBus.CurDuty    = curDuty;
      fanBus.FanState   = state;
      fanBus.PeriodTick = tick;
      forceOff          = stateNext == FAN_OFF;
   end

   fan_pwm_core core (
      .CLKi       (CLKi),
      .ResetNi    (ResetNi),
      .Duty       (dutyNext),
      .ForceOff   (forceOff),
      .FanPWM     (fanBus.FanPWM),
      .PeriodTick (tick)
   );
endmodule

// File: tb/tb_fan_pwm_gen.sv
// tb_fan_pwm_gen: cycle-level reference model feeds an expected-output queue checked every
// clock, plus scenario tasks with their own milestone checks.
module tb_fan_pwm_gen;
   import fan_pwm_gen_pkg::*;
   localparam int         KickP = 4;
   localparam int         RampD = 2;
   localparam int         HoldP = 8;
   localparam logic [7:0] MinD  = 8'hE0;
   localparam int         Per   = 256;

   typedef struct packed {
      logic       pwm;
      logic [7:0] duty;
      logic [2:0] st;
      logic       tick;
   } obs_t;

   logic       CLKi    = 1'b0;
   logic       ResetNi = 1'b0;
   int         nCmp    = 0;
   int         nBad    = 0;
   obs_t       expQ[$];
   fanState_t  mState;
   logic [7:0] mPcnt, mDuty;
   int         mKick, mRamp, mHold;

   fan_pwm_gen_if fanIf();

   fan_pwm_gen #(
      .KICK_PERIODS (KickP),
      .RAMP_DIV     (RampD),
      .MIN_DUTY     (MinD),
      .FAULT_HOLD   (HoldP)
   ) dut (
      .CLKi    (CLKi),
      .ResetNi (ResetNi),
      .fanBus  (fanIf.slave)
   );

   always #5 CLKi = ~CLKi;

   task automatic modelStep();
      logic       run;
      logic       tick;
      logic [7:0] tgt;
      if (!ResetNi) begin
         mState = FAN_OFF;
         mPcnt  = 8'h00;
         mDuty  = 8'h00;
         mKick  = 0;
         mRamp  = 0;
         mHold  = 0;
      end else begin
         tick = mPcnt == 8'hFF;
         run  = fanIf.Enable && fanIf.DutyReg != 8'h00;
         tgt  = (fanIf.DutyReg < MinD) ? MinD : fanIf.DutyReg;
         if (!run) begin
            if (tick) begin
               mState = FAN_OFF;
               mDuty  = 8'h00;
            end
         end else if (fanIf.TachFault) begin
            mState = FAN_FAILSAFE;
            mDuty  = 8'hFF;
            mHold  = 0;
         end else if (tick) begin
            case (mState)
               FAN_OFF: begin
                  mState = FAN_KICK;
                  mDuty  = 8'hFF;
                  mKick  = 0;
               end
               FAN_KICK: begin
                  mKick++;
                  if (mKick == KickP) begin
                     mState = FAN_RAMP;
                     mRamp  = 0;
                  end
               end
               FAN_RAMP: begin
                  if (mDuty != tgt) begin
                     mRamp++;
                     if (mRamp == RampD) begin
                        mRamp = 0;
                        mDuty = (mDuty < tgt) ? mDuty + 8'd1 : mDuty - 8'd1;
                     end
                  end
                  if (mDuty == tgt) mState = FAN_RUN;
               end
               FAN_RUN:
                  if (mDuty != tgt) begin
                     mState = FAN_RAMP;
                     mRamp  = 0;
                  end
               FAN_FAILSAFE: begin
                  mHold++;
                  if (mHold == HoldP) begin
                     mState = FAN_RAMP;
                     mRamp  = 0;
                  end
               end
               default: mState = FAN_OFF;
            endcase
         end
         mPcnt = mPcnt + 8'd1;
      end
      if (CLKi)
         expQ.push_back({mState != FAN_OFF && (mPcnt < mDuty || mDuty == 8'hFF), mDuty, mState, mPcnt == 8'hFF});
   endtask

   task automatic scoreCheck();
      obs_t e, a;
      if (expQ.size() == 0) return;
      e = expQ.pop_front();
      a = {fanIf.FanPWM, fanIf.CurDuty, fanIf.FanState, fanIf.PeriodTick};
      nCmp++;
      if (a !== e) begin
         nBad++;
         $display("FAIL scoreboard t=%0t: got pwm=%b duty=%h st=%0d tick=%b, expected pwm=%b duty=%h st=%0d tick=%b",
                  $time, a.pwm, a.duty, a.st, a.tick, e.pwm, e.duty, e.st, e.tick);
      end
   endtask

   always @(posedge CLKi or negedge ResetNi) modelStep();
   always @(negedge CLKi) scoreCheck();

   task automatic waitState(input fanState_t s, input int limit, output int n);
      n = 0;
      while (fanIf.FanState !== s && n < limit) begin
         @(negedge CLKi);
         n++;
      end
   endtask

   task automatic countHigh(output int h);
      h = 0;
      repeat (Per) begin
         @(negedge CLKi);
         if (fanIf.FanPWM === 1'b1) h++;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge CLKi);
      nCmp++;
      if (fanIf.FanPWM !== 1'b0 || fanIf.CurDuty !== 8'h00 || fanIf.FanState !== FAN_OFF || fanIf.PeriodTick !== 1'b0) begin
         nBad++;
         $display("FAIL reset: got pwm=%b duty=%h st=%0d tick=%b, expected 0/00/0/0",
                  fanIf.FanPWM, fanIf.CurDuty, fanIf.FanState, fanIf.PeriodTick);
      end
      ResetNi = 1'b1;
   endtask

   task automatic test_kick_ramp();
      int n, h;
      fanIf.Enable  = 1'b1;
      fanIf.DutyReg = 8'hF0;
      waitState(FAN_KICK, 2 * Per, n);
      nCmp++;
      if (fanIf.FanState !== FAN_KICK || fanIf.CurDuty !== 8'hFF) begin
         nBad++;
         $display("FAIL kick_entry: got st=%0d duty=%h, expected 1/ff", fanIf.FanState, fanIf.CurDuty);
      end
      waitState(FAN_RUN, 40 * Per, n);
      nCmp++;
      if (n != (KickP + 15 * RampD) * Per) begin
         nBad++;
         $display("FAIL kick_to_run_clocks: got %0d, expected %0d", n, (KickP + 15 * RampD) * Per);
      end
      nCmp++;
      if (fanIf.CurDuty !== 8'hF0) begin
         nBad++;
         $display("FAIL run_duty: got %h, expected f0", fanIf.CurDuty);
      end
      countHigh(h);
      nCmp++;
      if (h != 240) begin
         nBad++;
         $display("FAIL run_high_clocks: got %0d, expected 240", h);
      end
   endtask

   task automatic test_clamp();
      int n, h;
      fanIf.DutyReg = 8'h10;
      waitState(FAN_RAMP, 2 * Per, n);
      nCmp++;
      if (fanIf.FanState !== FAN_RAMP) begin
         nBad++;
         $display("FAIL clamp_ramp_entry: got st=%0d, expected 2", fanIf.FanState);
      end
      waitState(FAN_RUN, 40 * Per, n);
      nCmp++;
      if (n != 16 * RampD * Per) begin
         nBad++;
         $display("FAIL clamp_ramp_clocks: got %0d, expected %0d", n, 16 * RampD * Per);
      end
      nCmp++;
      if (fanIf.CurDuty !== MinD || fanIf.FanState !== FAN_RUN) begin
         nBad++;
         $display("FAIL clamp_duty: got duty=%h st=%0d, expected %h/3", fanIf.CurDuty, fanIf.FanState, MinD);
      end
      countHigh(h);
      nCmp++;
      if (h != 224) begin
         nBad++;
         $display("FAIL clamp_high_clocks: got %0d, expected 224", h);
      end
   endtask

   task automatic test_failsafe();
      int n;
      repeat (100) @(negedge CLKi);
      fanIf.TachFault = 1'b1;
      @(negedge CLKi);
      nCmp++;
      if (fanIf.FanState !== FAN_FAILSAFE || fanIf.CurDuty !== 8'hFF || fanIf.FanPWM !== 1'b1) begin
         nBad++;
         $display("FAIL failsafe_entry: got st=%0d duty=%h pwm=%b, expected 4/ff/1",
                  fanIf.FanState, fanIf.CurDuty, fanIf.FanPWM);
      end
      repeat (9) @(negedge CLKi);
      fanIf.TachFault = 1'b0;
      fanIf.DutyReg   = 8'hF8;
      repeat (5 * Per) @(negedge CLKi);
      nCmp++;
      if (fanIf.FanState !== FAN_FAILSAFE) begin
         nBad++;
         $display("FAIL failsafe_hold_early: got st=%0d, expected 4", fanIf.FanState);
      end
      fanIf.TachFault = 1'b1;
      repeat (10) @(negedge CLKi);
      fanIf.TachFault = 1'b0;
      waitState(FAN_RAMP, (HoldP + 2) * Per, n);
      nCmp++;
      if (fanIf.FanState !== FAN_RAMP || n <= (HoldP - 1) * Per || n > HoldP * Per) begin
         nBad++;
         $display("FAIL failsafe_hold_restart: got st=%0d after %0d clocks, expected 2 within (%0d,%0d]",
                  fanIf.FanState, n, (HoldP - 1) * Per, HoldP * Per);
      end
      waitState(FAN_RUN, 20 * Per, n);
      nCmp++;
      if (fanIf.FanState !== FAN_RUN || fanIf.CurDuty !== 8'hF8) begin
         nBad++;
         $display("FAIL failsafe_rampdown: got st=%0d duty=%h, expected 3/f8", fanIf.FanState, fanIf.CurDuty);
      end
   endtask

   task automatic test_disable_fault();
      int  n, h;
      logic saw;
      repeat (50) @(negedge CLKi);
      fanIf.Enable    = 1'b0;
      fanIf.TachFault = 1'b1;
      saw = 1'b0;
      n   = 0;
      while (fanIf.FanState !== FAN_OFF && n < 2 * Per) begin
         @(negedge CLKi);
         n++;
         if (fanIf.FanState === FAN_FAILSAFE) saw = 1'b1;
      end
      nCmp++;
      if (fanIf.FanState !== FAN_OFF || fanIf.CurDuty !== 8'h00 || fanIf.FanPWM !== 1'b0 || n > Per) begin
         nBad++;
         $display("FAIL disable_off: got st=%0d duty=%h pwm=%b after %0d clocks, expected 0/00/0 within %0d",
                  fanIf.FanState, fanIf.CurDuty, fanIf.FanPWM, n, Per);
      end
      nCmp++;
      if (saw !== 1'b0) begin
         nBad++;
         $display("FAIL disable_no_failsafe: got saw=%b, expected 0", saw);
      end
      countHigh(h);
      nCmp++;
      if (h != 0) begin
         nBad++;
         $display("FAIL disable_pwm_low: got %0d high clocks, expected 0", h);
      end
      fanIf.TachFault = 1'b0;
   endtask

   task automatic test_reversal();
      int         n, drop, glitch;
      logic [7:0] prev;
      logic       pwmPrev, tickPrev;
      fanIf.DutyReg = 8'hE0;
      fanIf.Enable  = 1'b1;
      waitState(FAN_RAMP, 6 * Per, n);
      n = 0;
      while (fanIf.CurDuty !== 8'hF0 && n < 40 * Per) begin
         @(negedge CLKi);
         n++;
      end
      nCmp++;
      if (fanIf.CurDuty !== 8'hF0 || fanIf.FanState !== FAN_RAMP) begin
         nBad++;
         $display("FAIL reverse_midpoint: got duty=%h st=%0d, expected f0/2", fanIf.CurDuty, fanIf.FanState);
      end
      fanIf.DutyReg = 8'hFC;
      prev     = fanIf.CurDuty;
      pwmPrev  = fanIf.FanPWM;
      tickPrev = fanIf.PeriodTick;
      drop     = 0;
      glitch   = 0;
      n        = 0;
      while (fanIf.FanState !== FAN_RUN && n < 40 * Per) begin
         @(negedge CLKi);
         n++;
         if (fanIf.CurDuty < prev) drop++;
         if (fanIf.FanPWM && !pwmPrev && !tickPrev) glitch++;
         prev     = fanIf.CurDuty;
         pwmPrev  = fanIf.FanPWM;
         tickPrev = fanIf.PeriodTick;
      end
      nCmp++;
      if (fanIf.FanState !== FAN_RUN || fanIf.CurDuty !== 8'hFC) begin
         nBad++;
         $display("FAIL reverse_run: got st=%0d duty=%h, expected 3/fc", fanIf.FanState, fanIf.CurDuty);
      end
      nCmp++;
      if (drop != 0) begin
         nBad++;
         $display("FAIL reverse_direction: got %0d decrements, expected 0", drop);
      end
      nCmp++;
      if (glitch != 0) begin
         nBad++;
         $display("FAIL reverse_glitch: got %0d mid-period rises, expected 0", glitch);
      end
   endtask

   task automatic test_reset_kick();
      int n, h;
      fanIf.Enable = 1'b0;
      waitState(FAN_OFF, 2 * Per, n);
      fanIf.DutyReg = 8'hFF;
      fanIf.Enable  = 1'b1;
      waitState(FAN_KICK, 2 * Per, n);
      repeat (2 * Per + 30) @(negedge CLKi);
      nCmp++;
      if (fanIf.FanState !== FAN_KICK || fanIf.FanPWM !== 1'b1) begin
         nBad++;
         $display("FAIL midkick_pre: got st=%0d pwm=%b, expected 1/1", fanIf.FanState, fanIf.FanPWM);
      end
      #2 ResetNi = 1'b0;
      #1;
      nCmp++;
      if (fanIf.FanPWM !== 1'b0 || fanIf.CurDuty !== 8'h00 || fanIf.FanState !== FAN_OFF) begin
         nBad++;
         $display("FAIL async_reset: got pwm=%b duty=%h st=%0d, expected 0/00/0",
                  fanIf.FanPWM, fanIf.CurDuty, fanIf.FanState);
      end
      repeat (3) @(negedge CLKi);
      ResetNi = 1'b1;
      waitState(FAN_KICK, 2 * Per, n);
      nCmp++;
      if (fanIf.FanState !== FAN_KICK || n != Per) begin
         nBad++;
         $display("FAIL rekick: got st=%0d after %0d clocks, expected 1 after %0d", fanIf.FanState, n, Per);
      end
      waitState(FAN_RAMP, (KickP + 1) * Per, n);
      nCmp++;
      if (n != KickP * Per) begin
         nBad++;
         $display("FAIL rekick_len: got %0d clocks, expected %0d", n, KickP * Per);
      end
      waitState(FAN_RUN, 2 * Per, n);
      nCmp++;
      if (fanIf.FanState !== FAN_RUN || fanIf.CurDuty !== 8'hFF || n != Per) begin
         nBad++;
         $display("FAIL full_target_run: got st=%0d duty=%h after %0d clocks, expected 3/ff after %0d",
                  fanIf.FanState, fanIf.CurDuty, n, Per);
      end
      countHigh(h);
      nCmp++;
      if (h != Per) begin
         nBad++;
         $display("FAIL full_high_clocks: got %0d, expected %0d", h, Per);
      end
   endtask

   initial begin
      fanIf.Enable    = 1'b0;
      fanIf.DutyReg   = 8'h00;
      fanIf.TachFault = 1'b0;
      test_reset();
      test_kick_ramp();
      test_clamp();
      test_failsafe();
      test_disable_fault();
      test_reversal();
      test_reset_kick();
      repeat (2) @(negedge CLKi);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
